uart_rx_regif: RTL and testbench

Downstream stage of the UART receiver. It is a CPU-facing register slave that pops received frames from the receiver FIFO and drives the receiver's control inputs. It also keeps sticky error flags and raises a level interrupt to the interrupt handler. It sits between the RISC core's peripheral bus and uart_receiver.

---
 rtl/uart_rx_regif_pkg.sv | 44 ++++
 rtl/uart_rx_regif.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_regif.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_regif_pkg.sv
// Shared definitions for the UART receiver register interface:
// register offsets, bit positions and the bus FSM state encoding.
package uart_rx_regif_pkg;

  // Word offsets (byte address bits [3:2])
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IE     = 2'd3;

  // STATUS bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_THR   = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OV    = 3;
  localparam int ST_FRE   = 4;
  localparam int ST_PE    = 5;

  // CTRL bit positions
  localparam int CTRL_W        = 5;
  localparam int CTRL_RX_EN    = 0;
  localparam int CTRL_PAR_EN   = 1;
  localparam int CTRL_PAR_TYPE = 2;
  localparam int CTRL_THR_LSB  = 3;

  // IE bit positions
  localparam int IE_W   = 3;
  localparam int IE_THR = 0;
  localparam int IE_OV  = 1;
  localparam int IE_ERR = 2;

  // RXDATA field positions
  localparam int RXDATA_VALID = 31;
  localparam int RXDATA_PE    = 9;
  localparam int RXDATA_FRE   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITQ = 2'd1,
    LATCH = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_rx_regif.sv
// CPU-facing register slave for the UART receiver: pops frames from the
// receiver FIFO, drives receiver control, keeps sticky errors, raises irq.
module uart_rx_regif
  import uart_rx_regif_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bus_cs,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_fre,
  input  logic              rx_pe,
  input  logic              rx_ov,
  input  logic              rx_thr,
  input  logic              rx_busy,
  input  logic              rx_empty,
  output logic              read_en,
  output logic              rx_en,
  output logic              parity_en,
  output logic              parity_type,
  output logic [1:0]        rx_thr_val,
  output logic              irq
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [IE_W-1:0]     ie_q, ie_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                ov_stk_q, ov_stk_d;
  logic                fre_stk_q, fre_stk_d;
  logic                pe_stk_q, pe_stk_d;
  logic                busy_p1_q, busy_p2_q;
  logic                irq_q, irq_d;
  logic                read_en_s;
  logic [2:0]          w1c_s;      // {pe, fre, ov} clear strobes
  logic                inhibit_s;
  logic [1:0]          reg_sel_s;
  logic [DATA_W-1:0]   status_word_s;
  logic [DATA_W-1:0]   rx_word_s;
  logic                unused_bits;

  assign reg_sel_s   = bus_addr[3:2];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[DATA_W-1:CTRL_W]};

  // The receiver may write its FIFO just after going idle; hold pops off then.
  assign inhibit_s = ~rx_busy & (busy_p1_q | busy_p2_q);

  // Assemble STATUS and RXDATA read words.
  always_comb begin
    status_word_s           = {DATA_W{1'b0}};
    status_word_s[ST_EMPTY] = rx_empty;
    status_word_s[ST_THR]   = rx_thr;
    status_word_s[ST_BUSY]  = rx_busy;
    status_word_s[ST_OV]    = ov_stk_q;
    status_word_s[ST_FRE]   = fre_stk_q;
    status_word_s[ST_PE]    = pe_stk_q;
    rx_word_s               = {DATA_W{1'b0}};
    rx_word_s[RXDATA_VALID] = 1'b1;
    rx_word_s[RXDATA_PE]    = rx_pe;
    rx_word_s[RXDATA_FRE]   = rx_fre;
    rx_word_s[7:0]          = rx_data;
  end

  // Bus FSM next state, register writes, read data and pop strobe.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    ie_d      = ie_q;
    rdata_d   = rdata_q;
    read_en_s = 1'b0;
    w1c_s     = 3'b000;
    case (state_q)
      IDLE: begin
        if (bus_cs) begin
          if (!bus_we && (reg_sel_s == REG_RXDATA)) begin
            state_d = WAITQ;
          end else begin
            state_d = RESP;
            if (bus_we) begin
              case (reg_sel_s)
                REG_STATUS: w1c_s  = {bus_wdata[ST_PE], bus_wdata[ST_FRE], bus_wdata[ST_OV]};
                REG_CTRL:   ctrl_d = bus_wdata[CTRL_W-1:0];
                REG_IE:     ie_d   = bus_wdata[IE_W-1:0];
                default:    ctrl_d = ctrl_q;
              endcase
            end else begin
              case (reg_sel_s)
                REG_STATUS: rdata_d = status_word_s;
                REG_CTRL:   rdata_d = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
                REG_IE:     rdata_d = {{(DATA_W-IE_W){1'b0}}, ie_q};
                default:    rdata_d = {DATA_W{1'b0}};
              endcase
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAITQ: begin
        if (inhibit_s) begin
          state_d = WAITQ;
        end else if (rx_empty) begin
          rdata_d = {DATA_W{1'b0}};
          state_d = RESP;
        end else begin
          read_en_s = 1'b1;
          state_d   = LATCH;
        end
      end
      LATCH: begin
        rdata_d = rx_word_s;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags (set beats clear), completion pulse and interrupt level.
  always_comb begin
    ov_stk_d  = (ov_stk_q & ~w1c_s[0]) | rx_ov;
    fre_stk_d = (fre_stk_q & ~w1c_s[1]) | ((state_q == LATCH) & rx_fre);
    pe_stk_d  = (pe_stk_q & ~w1c_s[2]) | ((state_q == LATCH) & rx_pe);
    ready_d   = (state_d == RESP) & (state_q != RESP);
    irq_d     = (ie_q[IE_THR] & rx_thr) | (ie_q[IE_OV] & ov_stk_q) |
                (ie_q[IE_ERR] & (fre_stk_q | pe_stk_q));
  end

  // State and register storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ctrl_q    <= {CTRL_W{1'b0}};
      ie_q      <= {IE_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      ready_q   <= 1'b0;
      ov_stk_q  <= 1'b0;
      fre_stk_q <= 1'b0;
      pe_stk_q  <= 1'b0;
      busy_p1_q <= 1'b0;
      busy_p2_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      ie_q      <= ie_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      ov_stk_q  <= ov_stk_d;
      fre_stk_q <= fre_stk_d;
      pe_stk_q  <= pe_stk_d;
      busy_p1_q <= rx_busy;
      busy_p2_q <= busy_p1_q;
      irq_q     <= irq_d;
    end
  end

  assign bus_rdata   = rdata_q;
  assign bus_ready   = ready_q;
  assign read_en     = read_en_s;
  assign rx_en       = ctrl_q[CTRL_RX_EN];
  assign parity_en   = ctrl_q[CTRL_PAR_EN];
  assign parity_type = ctrl_q[CTRL_PAR_TYPE];
  assign rx_thr_val  = ctrl_q[CTRL_THR_LSB+1:CTRL_THR_LSB];
  assign irq         = irq_q;

endmodule

// File: tb/tb_uart_rx_regif.sv
// Self-checking bench for uart_rx_regif: scoreboard of expected read data
// and latency, pushed at request time and popped at bus_ready.
module tb_uart_rx_regif;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bus_cs, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [7:0]  rx_data;
  logic        rx_fre, rx_pe, rx_ov, rx_thr, rx_busy, rx_empty;
  logic        read_en, rx_en, parity_en, parity_type, irq;
  logic [1:0]  rx_thr_val;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_regif #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .rx_data(rx_data), .rx_fre(rx_fre), .rx_pe(rx_pe), .rx_ov(rx_ov),
    .rx_thr(rx_thr), .rx_busy(rx_busy), .rx_empty(rx_empty),
    .read_en(read_en), .rx_en(rx_en), .parity_en(parity_en),
    .parity_type(parity_type), .rx_thr_val(rx_thr_val), .irq(irq)
  );

  always #5 clk = ~clk;

  // One bus transaction starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic ov_pulse, output logic [31:0] rd, output int lat,
                          output int npop, output int pop_at);
    lat = -1; npop = 0; pop_at = -1; rd = 32'h0;
    bus_cs = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    if (ov_pulse) rx_ov = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ov_pulse) rx_ov = 1'b0;
      if (read_en) begin
        npop++;
        if (pop_at < 0) pop_at = k;
      end
      if (bus_ready) begin
        lat = k;
        rd  = bus_rdata;
        break;
      end
    end
    bus_cs = 1'b0; bus_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    logic [3:0]  addrs [3] = '{4'h8, 4'hC, 4'h4};
    logic [31:0] vals  [3] = '{32'h0, 32'h0, 32'h1};
    total++;
    if ({irq, read_en, bus_ready, rx_en, parity_en, parity_type, rx_thr_val} !== 8'h00 ||
        bus_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got irq=%b ready=%b rdata=%h rx_en=%b thr=%b, want all 0",
               irq, bus_ready, bus_rdata, rx_en, rx_thr_val);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{vals[i], 1});
      bus_xfer(1'b0, addrs[i], 32'h0, 1'b0, rd, lat, np, pa);
      e = exp_q.pop_front();
      total++;
      if (rd !== e.rdata || lat !== e.lat) begin
        bad++;
        $display("FAIL reset_read[%0d]: got rdata=%h lat=%0d, want rdata=%h lat=%0d",
                 i, rd, lat, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_ctrl_ie();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    bus_xfer(1'b1, 4'h8, 32'h0000_001B, 1'b0, rd, lat, np, pa);
    total++;
    if (lat !== 1 || {rx_en, parity_en, parity_type, rx_thr_val} !== 5'b11011) begin
      bad++;
      $display("FAIL ctrl_pins: got lat=%0d pins=%b, want lat=1 pins=11011",
               lat, {rx_en, parity_en, parity_type, rx_thr_val});
    end
    exp_q.push_back('{32'h0000_001B, 1});
    bus_xfer(1'b0, 4'h8, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat) begin
      bad++;
      $display("FAIL ctrl_readback: got %h lat=%0d, want %h lat=%0d", rd, lat, e.rdata, e.lat);
    end
    bus_xfer(1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0, rd, lat, np, pa);
    exp_q.push_back('{32'h0000_0007, 1});
    bus_xfer(1'b0, 4'hC, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat) begin
      bad++;
      $display("FAIL ie_mask: got %h lat=%0d, want %h lat=%0d", rd, lat, e.rdata, e.lat);
    end
    bus_xfer(1'b1, 4'hC, 32'h0, 1'b0, rd, lat, np, pa);
  endtask

  task automatic test_pop();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    rx_data = 8'hA5; rx_fre = 1'b0; rx_pe = 1'b0; rx_empty = 1'b0;
    exp_q.push_back('{32'h8000_00A5, 3});
    bus_xfer(1'b0, 4'h0, 32'h0, 1'b0, rd, lat, np, pa);
    rx_empty = 1'b1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat || np !== 1 || pa !== 1) begin
      bad++;
      $display("FAIL pop_a5: got %h lat=%0d pops=%0d at=%0d, want %h lat=%0d pops=1 at=1",
               rd, lat, np, pa, e.rdata, e.lat);
    end
    total++;
    if (bus_rdata !== 32'h8000_00A5) begin
      bad++;
      $display("FAIL rdata_hold: got %h, want 800000a5", bus_rdata);
    end
    exp_q.push_back('{32'h0000_0000, 2});
    bus_xfer(1'b0, 4'h0, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat || np !== 0) begin
      bad++;
      $display("FAIL pop_empty: got %h lat=%0d pops=%0d, want %h lat=%0d pops=0",
               rd, lat, np, e.rdata, e.lat);
    end
  endtask

  task automatic test_inhibit();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    rx_busy = 1'b1; rx_empty = 1'b0; rx_data = 8'h3C;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.push_back('{32'h8000_003C, 5});
    lat = -1; np = 0; pa = -1; rd = 32'h0;
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin rx_busy = 1'b0; #1; end
      if (read_en) begin np++; if (pa < 0) pa = k; end
      if (bus_ready) begin lat = k; rd = bus_rdata; break; end
    end
    bus_cs = 1'b0; rx_empty = 1'b1;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat || np !== 1 || pa !== 3) begin
      bad++;
      $display("FAIL inhibit: got %h lat=%0d pops=%0d at=%0d, want %h lat=%0d pops=1 at=3",
               rd, lat, np, pa, e.rdata, e.lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    bus_xfer(1'b1, 4'hC, 32'h4, 1'b0, rd, lat, np, pa);
    rx_data = 8'h5A; rx_pe = 1'b1; rx_empty = 1'b0;
    exp_q.push_back('{32'h8000_025A, 3});
    bus_xfer(1'b0, 4'h0, 32'h0, 1'b0, rd, lat, np, pa);
    rx_pe = 1'b0; rx_empty = 1'b1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat || irq !== 1'b1) begin
      bad++;
      $display("FAIL pe_pop: got %h lat=%0d irq=%b, want %h lat=%0d irq=1",
               rd, lat, irq, e.rdata, e.lat);
    end
    exp_q.push_back('{32'h0000_0021, 1});
    bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat) begin
      bad++;
      $display("FAIL pe_status: got %h lat=%0d, want %h lat=%0d", rd, lat, e.rdata, e.lat);
    end
    bus_xfer(1'b1, 4'h4, 32'h20, 1'b0, rd, lat, np, pa);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL pe_w1c_irq: got irq=%b, want 0", irq);
    end
    // frame error path
    rx_data = 8'h11; rx_fre = 1'b1; rx_empty = 1'b0;
    exp_q.push_back('{32'h8000_0111, 3});
    bus_xfer(1'b0, 4'h0, 32'h0, 1'b0, rd, lat, np, pa);
    rx_fre = 1'b0; rx_empty = 1'b1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || lat !== e.lat || irq !== 1'b1) begin
      bad++;
      $display("FAIL fre_pop: got %h lat=%0d irq=%b, want %h lat=%0d irq=1",
               rd, lat, irq, e.rdata, e.lat);
    end
    exp_q.push_back('{32'h0000_0011, 1});
    bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata) begin
      bad++;
      $display("FAIL fre_status: got %h, want %h", rd, e.rdata);
    end
    bus_xfer(1'b1, 4'h4, 32'h10, 1'b0, rd, lat, np, pa);
    exp_q.push_back('{32'h0000_0001, 1});
    bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || irq !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared: got %h irq=%b, want %h irq=0", rd, irq, e.rdata);
    end
  endtask

  task automatic test_ov_thr();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    bus_xfer(1'b1, 4'hC, 32'h2, 1'b0, rd, lat, np, pa);
    rx_ov = 1'b1;
    @(posedge clk); #1;
    rx_ov = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL ov_irq_early: got irq=%b, want 0", irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL ov_irq: got irq=%b, want 1", irq);
    end
    // clear coinciding with a new overrun: set wins
    bus_xfer(1'b1, 4'h4, 32'h08, 1'b1, rd, lat, np, pa);
    exp_q.push_back('{32'h0000_0009, 1});
    bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || irq !== 1'b1) begin
      bad++;
      $display("FAIL ov_set_wins: got %h irq=%b, want %h irq=1", rd, irq, e.rdata);
    end
    bus_xfer(1'b1, 4'h4, 32'h08, 1'b0, rd, lat, np, pa);
    exp_q.push_back('{32'h0000_0001, 1});
    bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, rd, lat, np, pa);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rdata || irq !== 1'b0) begin
      bad++;
      $display("FAIL ov_clear: got %h irq=%b, want %h irq=0", rd, irq, e.rdata);
    end
    // threshold interrupt follows rx_thr one cycle later
    bus_xfer(1'b1, 4'hC, 32'h1, 1'b0, rd, lat, np, pa);
    rx_thr = 1'b1;
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL thr_irq: got irq=%b, want 1", irq);
    end
    rx_thr = 1'b0;
    bus_xfer(1'b1, 4'hC, 32'h0, 1'b0, rd, lat, np, pa);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat, np, pa; exp_t e;
    logic [3:0]  addrs [3] = '{4'h8, 4'hC, 4'h4};
    logic [31:0] vals  [3] = '{32'h0, 32'h0, 32'h1};
    bus_xfer(1'b1, 4'h8, 32'h1B, 1'b0, rd, lat, np, pa);
    bus_xfer(1'b1, 4'hC, 32'h2, 1'b1, rd, lat, np, pa);
    bus_xfer(1'b0, 4'hC, 32'h0, 1'b0, rd, lat, np, pa);
    total++;
    if (irq !== 1'b1 || rx_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup: got irq=%b rx_en=%b, want 1 1", irq, rx_en);
    end
    rx_data = 8'h77; rx_empty = 1'b0;
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
    @(posedge clk); #1;
    total++;
    if (read_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_pop: got read_en=%b, want 1", read_en);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({read_en, bus_ready, irq, rx_en, parity_en, parity_type, rx_thr_val} !== 8'h00 ||
        bus_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: got read_en=%b ready=%b irq=%b rx_en=%b rdata=%h, want all 0",
               read_en, bus_ready, irq, rx_en, bus_rdata);
    end
    bus_cs = 1'b0; rx_empty = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_ready: got bus_ready=%b, want 0", bus_ready);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{vals[i], 1});
      bus_xfer(1'b0, addrs[i], 32'h0, 1'b0, rd, lat, np, pa);
      e = exp_q.pop_front();
      total++;
      if (rd !== e.rdata || lat !== e.lat) begin
        bad++;
        $display("FAIL mid_regs[%0d]: got %h lat=%0d, want %h lat=%0d",
                 i, rd, lat, e.rdata, e.lat);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
    rx_data = 8'h00; rx_fre = 1'b0; rx_pe = 1'b0; rx_ov = 1'b0; rx_thr = 1'b0;
    rx_busy = 1'b0; rx_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ctrl_ie();
    test_pop();
    test_inhibit();
    test_errors();
    test_ov_thr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
